// File: rtl/lsu_pkg.sv
// lsu_pkg: operation/state encodings and stack constants shared by the load/store unit
package lsu_pkg;

   typedef enum logic [1:0] {OP_LD, OP_ST, OP_PUSH, OP_POP} op_t;
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   localparam logic [7:0] SP_RESET    = 8'hFF;
   localparam logic [7:0] STACK_LIMIT = 8'h80;

endpackage

// File: rtl/lsu_stack_ptr.sv
// lsu_stack_ptr: stack pointer register with inc/dec and overflow/underflow guard
// Guard compares are active only when LSU_STACK_GUARD_EN is defined.
module lsu_stack_ptr
   import lsu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   output logic [7:0] sp,
   output logic [7:0] sp_plus1,
   output logic       push_ok,
   output logic       pop_ok
);

   assign sp_plus1 = sp + 8'd1;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         sp <= SP_RESET;
      else if (push)
         sp <= sp - 8'd1;
      else if (pop)
         sp <= sp_plus1;

`ifdef LSU_STACK_GUARD_EN
   assign push_ok = sp >= STACK_LIMIT;
   assign pop_ok  = sp != SP_RESET;
`else
   assign push_ok = 1'b1;
   assign pop_ok  = 1'b1;
`endif

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit in front of the 256x8 data memory; one LD/ST/PUSH/POP every 3 cycles
// Optional stack guard and sticky fault flag enabled by defining LSU_STACK_GUARD_EN.
module lsu
   import lsu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_op,
   input  logic [7:0] req_addr,
   input  logic [7:0] req_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic [7:0] sp,
   output logic       fault,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_dat_in,
   output logic       mem_wr_en,
   input  logic [7:0] mem_dat_out
);

   state_t     state, state_nx;
   op_t        op_q;
   logic [7:0] addr_q, data_q, sp_plus1;
   logic       push_ok, pop_ok, exec, is_push, is_pop, op_ok;

   assign exec    = state == S_EXEC;
   assign is_push = op_q == OP_PUSH;
   assign is_pop  = op_q == OP_POP;
   assign op_ok   = is_push ? push_ok : is_pop ? pop_ok : 1'b1;

   lsu_stack_ptr u_sp (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (exec & is_push & push_ok),
      .pop      (exec & is_pop & pop_ok),
      .sp       (sp),
      .sp_plus1 (sp_plus1),
      .push_ok  (push_ok),
      .pop_ok   (pop_ok)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nx;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         op_q   <= OP_LD;
         addr_q <= 8'h00;
         data_q <= 8'h00;
      end else if (state == S_IDLE && req_valid) begin
         op_q   <= op_t'(req_op);
         addr_q <= req_addr;
         data_q <= req_data;
      end

   // Illegal stack ops answer with zero; loads/pops return memory, writes echo their data.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         rsp_data <= 8'h00;
      else if (exec)
         rsp_data <= !op_ok ? 8'h00 : (op_q == OP_LD || is_pop) ? mem_dat_out : data_q;

   // Memory strobes decode purely from state so an async reset kills a write at once.
   always_comb begin
      state_nx   = state;
      req_ready  = 1'b0;
      mem_addr   = 8'h00;
      mem_dat_in = 8'h00;
      mem_wr_en  = 1'b0;
      if (state == S_IDLE) begin
         req_ready = 1'b1;
         state_nx  = req_valid ? S_EXEC : S_IDLE;
      end else if (exec) begin
         state_nx   = S_RESP;
         mem_addr   = is_push ? sp : is_pop ? sp_plus1 : addr_q;
         mem_dat_in = data_q;
         mem_wr_en  = op_ok & (op_q == OP_ST || is_push);
      end else begin
         state_nx = S_IDLE;
      end
   end

   assign rsp_valid = state == S_RESP;

`ifdef LSU_STACK_GUARD_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         fault <= 1'b0;
      else if (exec && !op_ok)
         fault <= 1'b1;
`else
   assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized and directed checks of lsu against a timestamp-based reference model
module tb_lsu;

`ifdef LSU_STACK_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic       clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0;
   logic [1:0] req_op = 2'd0;
   logic [7:0] req_addr = 8'h00, req_data = 8'h00;
   logic       req_ready, rsp_valid, fault, mem_wr_en;
   logic [7:0] rsp_data, sp, mem_addr, mem_dat_in, mem_dat_out;

   always #5 clk = ~clk;

   lsu dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .sp          (sp),
      .fault       (fault),
      .mem_addr    (mem_addr),
      .mem_dat_in  (mem_dat_in),
      .mem_wr_en   (mem_wr_en),
      .mem_dat_out (mem_dat_out)
   );

   // data memory: combinational read, synchronous write, preloaded with a known pattern
   logic [7:0] dm [256];
   logic       dm_init = 1'b1;
   assign mem_dat_out = dm[mem_addr];
   always @(posedge clk)
      if (dm_init)
         for (int i = 0; i < 256; i++) dm[i] <= 8'(i) ^ 8'h5A;
      else if (mem_wr_en)
         dm[mem_addr] <= mem_dat_in;

   int n_chk = 0, n_fail = 0, we_cnt = 0, rsp_cnt = 0, last_lat = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic bit push_legal(input logic [7:0] s);
      return !GUARD || s >= 8'h80;
   endfunction

   function automatic bit pop_legal(input logic [7:0] s);
      return !GUARD || s != 8'hFF;
   endfunction

   // Reference: an accepted op completes at the following edge; everything else is timed
   // by cycles elapsed since acceptance (1: memory access, 2: response, >=3: ready again).
   logic [7:0] ref_mem [256];
   int         cyc, t_acc;
   logic       pend;
   logic [1:0] p_op;
   logic [7:0] p_addr, p_data, m_sp, m_rsp;
   logic       m_fault;

   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cyc     <= 0;
         t_acc   <= -10;
         pend    <= 1'b0;
         m_sp    <= 8'hFF;
         m_fault <= 1'b0;
         m_rsp   <= 8'h00;
         if (dm_init)
            for (int i = 0; i < 256; i++) ref_mem[i] <= 8'(i) ^ 8'h5A;
      end else begin
         cyc <= cyc + 1;
         if (!pend && req_valid && cyc - t_acc >= 3) begin
            pend   <= 1'b1;
            t_acc  <= cyc;
            p_op   <= req_op;
            p_addr <= req_addr;
            p_data <= req_data;
         end else if (pend && cyc == t_acc + 1) begin
            pend <= 1'b0;
            case (p_op)
               2'd0: m_rsp <= ref_mem[p_addr];
               2'd1: begin ref_mem[p_addr] <= p_data; m_rsp <= p_data; end
               2'd2:
                  if (push_legal(m_sp)) begin
                     ref_mem[m_sp] <= p_data;
                     m_sp  <= m_sp - 8'd1;
                     m_rsp <= p_data;
                  end else begin
                     m_rsp   <= 8'h00;
                     m_fault <= 1'b1;
                  end
               default:
                  if (pop_legal(m_sp)) begin
                     m_rsp <= ref_mem[8'(m_sp + 8'd1)];
                     m_sp  <= m_sp + 8'd1;
                  end else begin
                     m_rsp   <= 8'h00;
                     m_fault <= 1'b1;
                  end
            endcase
         end
      end

   always @(negedge clk) begin : cmp
      int d;
      if (rst_n && !dm_init) begin
         d = cyc - t_acc;
         if (mem_wr_en) we_cnt++;
         if (rsp_valid) rsp_cnt++;
         chk("req_ready", {31'd0, req_ready}, {31'd0, d >= 3});
         chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, d == 2});
         chk("sp", {24'd0, sp}, {24'd0, m_sp});
         chk("fault", {31'd0, fault}, {31'd0, m_fault});
         if (d == 2) chk("rsp_data", {24'd0, rsp_data}, {24'd0, m_rsp});
         if (d == 1) begin
            chk("mem_wr_en", {31'd0, mem_wr_en},
                {31'd0, p_op == 2'd1 || (p_op == 2'd2 && push_legal(m_sp))});
            chk("mem_addr", {24'd0, mem_addr},
                {24'd0, p_op == 2'd2 ? m_sp : p_op == 2'd3 ? 8'(m_sp + 8'd1) : p_addr});
            chk("mem_dat_in", {24'd0, mem_dat_in}, {24'd0, p_data});
         end else begin
            chk("mem_idle", {15'd0, mem_wr_en, mem_addr, mem_dat_in}, 32'd0);
         end
      end
   end

   task automatic reset_dut();
      @(negedge clk);
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
   endtask

   // called just after a negedge; returns at the negedge showing the response
   task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] r);
      int n;
      req_op = op; req_addr = a; req_data = d; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      chk("ready_timeout", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
      chk("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
      last_lat = n;
      r = rsp_data;
   endtask

   initial begin
      logic [7:0] r;
      int w0, r0, lo, seen, bad;
      repeat (3) @(negedge clk);
      dm_init = 1'b0;
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_sp", {24'd0, sp}, 32'hFF);
      chk("rst_rsp_data", {24'd0, rsp_data}, 32'h0);
      chk("rst_fault", {31'd0, fault}, 32'd0);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);

      w0 = we_cnt;
      do_op(2'd1, 8'h10, 8'hA5, r);
      chk("st_we_once", we_cnt - w0, 32'd1);
      chk("st_rsp", {24'd0, r}, 32'hA5);
      do_op(2'd0, 8'h10, 8'h00, r);
      chk("ld_data", {24'd0, r}, 32'hA5);
      chk("ld_latency", last_lat, 32'd1);

      reset_dut();
      do_op(2'd2, 8'h00, 8'h11, r);
      chk("push1_sp", {24'd0, sp}, 32'hFE);
      do_op(2'd2, 8'h00, 8'h22, r);
      chk("push2_sp", {24'd0, sp}, 32'hFD);
      chk("dm_ff", {24'd0, dm[8'hFF]}, 32'h11);
      chk("dm_fe", {24'd0, dm[8'hFE]}, 32'h22);
      do_op(2'd3, 8'h00, 8'h00, r);
      chk("pop1_data", {24'd0, r}, 32'h22);
      chk("pop1_sp", {24'd0, sp}, 32'hFE);
      do_op(2'd3, 8'h00, 8'h00, r);
      chk("pop2_data", {24'd0, r}, 32'h11);
      chk("pop2_sp", {24'd0, sp}, 32'hFF);

      @(negedge clk);
      req_op = 2'd0; req_addr = 8'h05; req_valid = 1'b1;
      r0 = rsp_cnt; lo = 0;
      repeat (30) begin @(negedge clk); lo += int'(!req_ready); end
      req_valid = 1'b0;
      chk("hold_rsp_count", rsp_cnt - r0, 32'd10);
      chk("hold_busy_cycles", lo, 32'd20);

      @(negedge clk);
      req_op = 2'd1; req_addr = 8'h20; req_data = 8'h55; req_valid = 1'b1;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("abort_we", {31'd0, mem_wr_en}, 32'd0);
      req_valid = 1'b0;
      seen = 0;
      repeat (2) begin @(negedge clk); seen += int'(rsp_valid); end
      #2 rst_n = 1'b1;
      repeat (3) begin @(negedge clk); seen += int'(rsp_valid); end
      chk("abort_no_rsp", seen, 32'd0);
      chk("abort_dm20", {24'd0, dm[8'h20]}, 32'h7A);
      chk("abort_sp", {24'd0, sp}, 32'hFF);
      chk("abort_idle", {31'd0, req_ready}, 32'd1);

`ifdef LSU_STACK_GUARD_EN
      reset_dut();
      w0 = we_cnt;
      do_op(2'd3, 8'h00, 8'h99, r);
      chk("gpop_rsp", {24'd0, r}, 32'h0);
      chk("gpop_fault", {31'd0, fault}, 32'd1);
      chk("gpop_sp", {24'd0, sp}, 32'hFF);
      chk("gpop_no_write", we_cnt - w0, 32'd0);
      do_op(2'd0, 8'h10, 8'h00, r);
      chk("gfault_sticky", {31'd0, fault}, 32'd1);
      reset_dut();
      chk("gfault_clear", {31'd0, fault}, 32'd0);
      for (int i = 0; i < 128; i++) do_op(2'd2, 8'h00, 8'(i), r);
      chk("glimit_sp", {24'd0, sp}, 32'h7F);
      chk("glimit_nofault", {31'd0, fault}, 32'd0);
      do_op(2'd2, 8'h00, 8'hEE, r);
      chk("gpush_rsp", {24'd0, r}, 32'h0);
      chk("gpush_fault", {31'd0, fault}, 32'd1);
      chk("gpush_sp", {24'd0, sp}, 32'h7F);
`else
      reset_dut();
      for (int i = 0; i < 256; i++) do_op(2'd2, 8'h00, 8'(i), r);
      chk("wrap_sp", {24'd0, sp}, 32'hFF);
      chk("wrap_fault", {31'd0, fault}, 32'd0);
      do_op(2'd2, 8'h00, 8'hC3, r);
      chk("wrap_dm_ff", {24'd0, dm[8'hFF]}, 32'hC3);
      chk("wrap_sp2", {24'd0, sp}, 32'hFE);
`endif

      reset_dut();
      for (int i = 0; i < 400; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         do_op(2'($urandom_range(0, 3)),
               ($urandom & 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(240, 255)),
               8'($urandom), r);
      end
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < 256; i++) bad += int'(dm[i] !== ref_mem[i]);
      chk("mem_image", bad, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
